// File: rtl/sample_frame_scheduler.sv
// sample_frame_scheduler: parses host sample frames into the sample table, runs the
// processor start/done handshake and returns saturated error sums (or a NAK) over UART.
module sample_frame_scheduler #(
    parameter int NUM_SAMPLES = 32,
    parameter int ADDR_W      = $clog2(NUM_SAMPLES),
    parameter int RX_TIMEOUT  = 100000
) (
    input  logic              iClock,
    input  logic              iResetN,
    input  logic              iRxValid,
    input  logic [7:0]        iRxData,
    output logic              oTxValid,
    output logic [7:0]        oTxData,
    input  logic              iTxReady,
    output logic              oTableWrite,
    output logic [ADDR_W-1:0] oTableAddr,
    output logic [7:0]        oTableInput,
    output logic [7:0]        oTableExpected,
    output logic [7:0]        oTableValid,
    output logic [7:0]        oSequencesToProcess,
    output logic              oStartProcessing,
    input  logic              iReadyToProcess,
    input  logic              iDoneProcessing,
    input  logic [7:0][31:0]  iErrorSums,
    output logic              oDoneProcessingFeedback,
    output logic              oBusy,
    output logic              oFrameError
);
    typedef enum logic [2:0] {HUNT, COUNT, PAYLOAD, CHECK, START, WAIT_DONE, TX_RESULT, TX_NAK} state_t;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(RX_TIMEOUT - 1);
    localparam logic [7:0] N_MAX = 8'(NUM_SAMPLES);

    state_t            state_q, state_d;
    logic              err_q, err_d, wr_q, wr_d, fb_q, fb_d;
    logic [ADDR_W:0]   n_q, n_d, idx_q, idx_d;
    logic [1:0]        ph_q, ph_d;
    logic [7:0]        cs_q, cs_d, in_q, in_d, exp_q, exp_d, val_q, val_d, seq_q, seq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0][7:0]   sat_q, sat_d;
    logic [3:0]        tx_q, tx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        res_cs;

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q <= HUNT;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            fb_q    <= 1'b0;
            n_q     <= '0;
            idx_q   <= '0;
            ph_q    <= '0;
            cs_q    <= '0;
            in_q    <= '0;
            exp_q   <= '0;
            val_q   <= '0;
            seq_q   <= '0;
            addr_q  <= '0;
            sat_q   <= '0;
            tx_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            fb_q    <= fb_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            cs_q    <= cs_d;
            in_q    <= in_d;
            exp_q   <= exp_d;
            val_q   <= val_d;
            seq_q   <= seq_d;
            addr_q  <= addr_d;
            sat_q   <= sat_d;
            tx_q    <= tx_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        fb_d    = 1'b0;
        n_d     = n_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        cs_d    = cs_q;
        in_d    = in_q;
        exp_d   = exp_q;
        val_d   = val_q;
        seq_d   = seq_q;
        addr_d  = addr_q;
        sat_d   = sat_q;
        tx_d    = tx_q;
        tmo_d   = tmo_q;
        case (state_q)
            HUNT: if (iRxValid && iRxData == 8'hA5) begin
                state_d = COUNT;
                err_d   = 1'b0;
                cs_d    = 8'h00;
            end
            COUNT: if (iRxValid) begin
                if (iRxData == 8'h00 || iRxData > N_MAX) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else begin
                    n_d     = iRxData[ADDR_W:0];
                    idx_d   = '0;
                    ph_d    = 2'd0;
                    cs_d    = cs_q ^ iRxData;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (iRxValid) begin
                cs_d = cs_q ^ iRxData;
                if (idx_q == n_q) begin
                    state_d = CHECK;
                end else begin
                    ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
                    if (ph_q == 2'd0) in_d = iRxData;
                    if (ph_q == 2'd1) exp_d = iRxData;
                    if (ph_q == 2'd2) begin
                        val_d  = iRxData;
                        wr_d   = 1'b1;
                        addr_d = idx_q[ADDR_W-1:0];
                        idx_d  = idx_q + (ADDR_W+1)'(1);
                    end
                end
            end
            // Accumulator includes the received checksum, so a good frame folds to zero.
            CHECK: if (cs_q == 8'h00) begin
                seq_d   = 8'(n_q);
                state_d = START;
            end else begin
                err_d   = 1'b1;
                state_d = TX_NAK;
            end
            START: if (iReadyToProcess) state_d = WAIT_DONE;
            WAIT_DONE: if (iDoneProcessing) begin
                fb_d = 1'b1;
                for (int i = 0; i < 8; i++)
                    sat_d[i] = (|iErrorSums[i][31:8]) ? 8'hFF : iErrorSums[i][7:0];
                tx_d    = 4'd0;
                state_d = TX_RESULT;
            end
            TX_RESULT: if (iTxReady) begin
                tx_d    = (tx_q == 4'd9) ? 4'd0 : tx_q + 4'd1;
                state_d = (tx_q == 4'd9) ? HUNT : TX_RESULT;
            end
            TX_NAK: if (iTxReady) state_d = HUNT;
            default: state_d = HUNT;
        endcase
        if (state_q == COUNT || state_q == PAYLOAD || state_d == COUNT) begin
            tmo_d = (iRxValid || state_q == HUNT) ? '0 : tmo_q + TW'(1);
            if (!iRxValid && state_q != HUNT && tmo_q == T_LAST) begin
                err_d   = 1'b1;
                state_d = HUNT;
            end
        end
    end

    always_comb begin
        res_cs = 8'h5A;
        for (int i = 0; i < 8; i++) res_cs = res_cs ^ sat_q[i];
    end

    always_comb begin
        oTxValid                = (state_q == TX_RESULT) || (state_q == TX_NAK);
        oTxData                 = (state_q == TX_NAK) ? 8'hEE :
                                  (state_q != TX_RESULT) ? 8'h00 :
                                  (tx_q == 4'd0) ? 8'h5A :
                                  (tx_q == 4'd9) ? res_cs : sat_q[3'(tx_q - 4'd1)];
        oTableWrite             = wr_q;
        oTableAddr              = addr_q;
        oTableInput             = in_q;
        oTableExpected          = exp_q;
        oTableValid             = val_q;
        oSequencesToProcess     = seq_q;
        oStartProcessing        = (state_q == START) && iReadyToProcess;
        oDoneProcessingFeedback = fb_q;
        oBusy                   = state_q != HUNT;
        oFrameError             = err_q;
    end
endmodule
